// File: rtl/axi4_lite_pkg.sv
// Shared encodings for the AXI4-Lite register slave: response codes and the
// write/read channel FSM states.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Bank of NUM_REGS 32-bit registers: one byte-strobed synchronous write port
// and one asynchronous read port (reads see the pre-write value on a write edge).
module axi4_lite_reg_bank #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[ridx];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers. Independent write and
// read FSMs; every output is a flop or a decode of flops only.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY
);

    localparam int IDX_W = $clog2(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(NUM_REGS * 4);
    endfunction

    // Keeps all READYs low while in reset and through the reset edge itself.
    logic              rdy_en_q, rdy_en_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [0:0]        wstate_q, wstate_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [0:0]        rstate_q, rstate_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs, w_hs, ar_hs, bank_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data, bank_rdata;
    logic [3:0]        wr_strb;

    assign AWREADY = rdy_en_q && !aw_held_q && (wstate_q == W_IDLE);
    assign WREADY  = rdy_en_q && !w_held_q && (wstate_q == W_IDLE);
    assign BVALID  = (wstate_q == W_RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = rdy_en_q && (rstate_q == R_IDLE);
    assign RVALID  = (rstate_q == R_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // A held beat wins over the live bus; the live value is used when it handshakes now.
    assign wr_addr = aw_held_q ? awaddr_q : AWADDR;
    assign wr_data = w_held_q ? wdata_q : WDATA;
    assign wr_strb = w_held_q ? wstrb_q : WSTRB;

    always_comb begin
        rdy_en_d  = 1'b1;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wstate_d  = wstate_q;
        bresp_d   = bresp_q;
        bank_we   = 1'b0;
        if (wstate_q == W_IDLE) begin
            if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                bank_we   = in_range(wr_addr);
                bresp_d   = in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                wstate_d  = W_RESP;
            end else begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
            end
        end else if (BREADY) begin
            wstate_d = W_IDLE;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rstate_q == R_IDLE) begin
            if (ar_hs) begin
                rdata_d  = in_range(ARADDR) ? bank_rdata : 32'h0;
                rresp_d  = in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
                rstate_d = R_DATA;
            end
        end else if (RREADY) begin
            rstate_d = R_IDLE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wstate_q  <= W_IDLE;
            bresp_q   <= RESP_OKAY;
            rstate_q  <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wstate_q  <= wstate_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    axi4_lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (bank_we),
        .widx  (wr_addr[IDX_W+1:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .ridx  (ARADDR[IDX_W+1:2]),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: a table of write/read vectors with expected
// responses queued at drive time, plus hand sequences for multi-cycle cases.
module tb_axi4_lite_slave_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi4_lite_slave_regs #(.NUM_REGS(8), .ADDR_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    vec_t        vecs[17];
    logic [1:0]  bq[$];
    rexp_t       rq[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake not seen within cycle budget", nm);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        int n;
        bit hs_aw, hs_w;
        logic [1:0] e;
        bq.push_back(resp);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        n = 0;
        while ((AWVALID || WVALID) && n < 20) begin
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            tick();
            if (hs_aw) AWVALID = 1'b0;
            if (hs_w) WVALID = 1'b0;
            n++;
        end
        if (AWVALID || WVALID) begin
            timeout("wr_handshake");
            AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
            void'(bq.pop_back());
            return;
        end
        chk("wr_bvalid_latency", {31'b0, BVALID}, 32'd1);
        e = bq.pop_front();
        chk("wr_bresp", {30'b0, BRESP}, {30'b0, e});
        tick();
        BREADY = 1'b0;
        chk("wr_bvalid_clear", {31'b0, BVALID}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n;
        bit hs;
        rexp_t e;
        rq.push_back('{data, resp});
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        n = 0;
        while (ARVALID && n < 20) begin
            hs = ARREADY;
            tick();
            if (hs) ARVALID = 1'b0;
            n++;
        end
        if (ARVALID) begin
            timeout("rd_handshake");
            ARVALID = 1'b0; RREADY = 1'b0;
            void'(rq.pop_back());
            return;
        end
        chk("rd_rvalid_latency", {31'b0, RVALID}, 32'd1);
        e = rq.pop_front();
        chk("rd_rdata", RDATA, e.data);
        chk("rd_rresp", {30'b0, RRESP}, {30'b0, e.resp});
        tick();
        RREADY = 1'b0;
        chk("rd_rvalid_clear", {31'b0, RVALID}, 32'd0);
    endtask

    task automatic chk_readies(input string nm, input logic [2:0] exp);
        chk(nm, {29'b0, AWREADY, WREADY, ARREADY}, {29'b0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {is_wr, addr, data, strb, expected resp, expected read data}
        vecs[0]  = '{1'b0, 32'h0000000C, 32'h0,        4'h0, 2'b00, 32'h00000000};
        vecs[1]  = '{1'b1, 32'h00000004, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 32'h00000004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 32'h00000000, 32'h11223344, 4'hF, 2'b00, 32'h0};
        vecs[4]  = '{1'b1, 32'h00000000, 32'h0000A500, 4'h2, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 2'b00, 32'h1122A544};
        vecs[6]  = '{1'b1, 32'h00000020, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[7]  = '{1'b0, 32'h00000020, 32'h0,        4'h0, 2'b10, 32'h00000000};
        vecs[8]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 2'b00, 32'h1122A544};
        vecs[9]  = '{1'b0, 32'h00000007, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 32'h0000001C, 32'hCAFEF00D, 4'h0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'h0000001C, 32'h0,        4'h0, 2'b00, 32'h00000000};
        vecs[12] = '{1'b1, 32'h0000001D, 32'h12345678, 4'h9, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 32'h0000001C, 32'h0,        4'h0, 2'b00, 32'h12000078};
        vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 2'b10, 32'h00000000};
        vecs[15] = '{1'b1, 32'h00000100, 32'h99999999, 4'hF, 2'b10, 32'h0};
        vecs[16] = '{1'b0, 32'h00000000, 32'h0,        4'h0, 2'b00, 32'h1122A544};

        ARESET = 1'b1;
        AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) tick();
        chk_readies("rst_readies", 3'b000);
        chk("rst_bvalid", {31'b0, BVALID}, 32'd0);
        chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_resps", {28'b0, BRESP, RRESP}, 32'h0);
        ARESET = 1'b0;
        tick();
        chk_readies("post_rst_readies", 3'b111);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else               do_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
        end

        // W arrives three cycles ahead of AW
        WDATA = 32'h5A5A0001; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        chk("w_first_wready", {31'b0, WREADY}, 32'd1);
        tick();
        WVALID = 1'b0;
        chk("w_held_wready", {31'b0, WREADY}, 32'd0);
        chk("w_held_bvalid", {31'b0, BVALID}, 32'd0);
        repeat (2) begin
            tick();
            chk("w_wait_bvalid", {31'b0, BVALID}, 32'd0);
            chk("w_wait_readies", {30'b0, AWREADY, WREADY}, 32'b10);
        end
        AWADDR = 32'h00000008; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("aw_late_bvalid", {31'b0, BVALID}, 32'd1);
        chk("aw_late_bresp", {30'b0, BRESP}, 32'd0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("aw_late_bclear", {31'b0, BVALID}, 32'd0);
        chk_readies("aw_late_readies", 3'b111);
        do_read(32'h00000008, 32'h5A5A0001, 2'b00);

        // Concurrent write + read with both response channels back-pressured
        AWADDR = 32'h0000000C; WDATA = 32'h0C0C0C0C; WSTRB = 4'hF; ARADDR = 32'h00000004;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rvalid", {31'b0, RVALID}, 32'd1);
            chk("bp_rdata", RDATA, 32'hDEADBEEF);
            chk("bp_bvalid_bresp", {29'b0, BVALID, BRESP}, 32'b100);
            chk("bp_rresp", {30'b0, RRESP}, 32'd0);
            chk_readies("bp_readies", 3'b000);
            tick();
        end
        chk("bp_hold_end", {30'b0, BVALID, RVALID}, 32'b11);
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        chk("bp_release", {30'b0, BVALID, RVALID}, 32'b00);
        chk_readies("bp_release_readies", 3'b111);
        do_read(32'h0000000C, 32'h0C0C0C0C, 2'b00);

        // Read on the same edge as a write commit to the same register
        do_write(32'h00000010, 32'h0BADF00D, 4'hF, 2'b00);
        AWADDR = 32'h00000010; WDATA = 32'h600DCAFE; WSTRB = 4'hF; ARADDR = 32'h00000010;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("raw_same_edge_valids", {30'b0, BVALID, RVALID}, 32'b11);
        chk("raw_same_edge_rdata", RDATA, 32'h0BADF00D);
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        do_read(32'h00000010, 32'h600DCAFE, 2'b00);

        // Reset while a write response is pending
        AWADDR = 32'h00000018; WDATA = 32'h77777777; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("pre_rst_bvalid", {31'b0, BVALID}, 32'd1);
        ARESET = 1'b1;
        tick();
        chk("mid_rst_bvalid", {31'b0, BVALID}, 32'd0);
        chk_readies("mid_rst_readies", 3'b000);
        ARESET = 1'b0;
        tick();
        chk_readies("after_rst_readies", 3'b111);
        for (int r = 0; r < 8; r++) do_read(32'(r * 4), 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, giving the number of 32-bit registers (power of two, 2..64).
REQ-003 The block SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-004 ACLK  input  1  clock; all logic on rising edge.
REQ-005 ARESET  input  1  synchronous active-high reset.
REQ-006 AWADDR  input  ADDR_W  write address.
REQ-007 AWVALID / AWREADY  input / output  1  write-address handshake.
REQ-008 WDATA  input  32  write data.
REQ-009 WSTRB  input  4  byte-lane enables; bit i enables WDATA[8i+7:8i].
REQ-010 WVALID / WREADY  input / output  1  write-data handshake.
REQ-011 BRESP  output  2  write response, 00 OKAY, 10 SLVERR.
REQ-012 BVALID / BREADY  output / input  1  write-response handshake.
REQ-013 ARADDR  input  ADDR_W  read address.
REQ-014 ARVALID / ARREADY  input / output  1  read-address handshake.
REQ-015 RDATA  output  32  read data.
REQ-016 RRESP  output  2  read response, 00 OKAY, 10 SLVERR.
REQ-017 RVALID / RREADY  output / input  1  read-data handshake.

Function
REQ-018 Handshake SHALL complete on a rising edge where VALID and READY are both high; outputs SHALL be registered, with no combinational path from any input to any output.
REQ-019 AW and W SHALL be accepted independently in either order: AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID; the held flag sets on its channel's handshake.
REQ-020 Write FSM SHALL have states W_IDLE and W_RESP: on the edge where address and data are both available (held or handshaking now), commit the write, clear the held flags, set BVALID, and enter W_RESP.
REQ-021 Write latency SHALL be: AW+W handshake at edge N -> register updated and BVALID=1 after edge N.
REQ-022 In W_RESP, BVALID and BRESP SHALL remain stable until BREADY; the BVALID/BREADY handshake SHALL return the FSM to W_IDLE, where AWREADY/WREADY go high the next cycle.
REQ-023 Decode SHALL use register index addr[log2(NUM_REGS)+1:2]; addr[1:0] SHALL be ignored; addr >= NUM_REGS*4 SHALL be out of range.
REQ-024 In-range writes SHALL update only strobed bytes and return OKAY; WSTRB=0000 SHALL return OKAY with no change; out-of-range writes SHALL return SLVERR and change no register.
REQ-025 Read FSM SHALL have states R_IDLE and R_DATA: ARREADY=1 only in R_IDLE; AR handshake at edge N SHALL load RDATA/RRESP and set RVALID=1 after edge N.
REQ-026 RDATA/RRESP SHALL hold stable while RVALID && !RREADY; the RVALID/RREADY handshake SHALL return the FSM to R_IDLE.
REQ-027 Out-of-range reads SHALL return RDATA=0 and RRESP=SLVERR.
REQ-028 An AR handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-029 Read and write FSMs SHALL run concurrently with no mutual stall.

Reset
REQ-030 While ARESET=1 at an edge, all registers SHALL become 0x00000000, held flags SHALL clear, FSMs SHALL go to W_IDLE/R_IDLE, and BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
REQ-031 AWREADY, WREADY and ARREADY SHALL be 0 during reset and SHALL be 1 the first cycle after ARESET falls; reset mid-transaction SHALL drop the transaction silently.

Structure
REQ-032 Package axi4_lite_pkg SHALL hold RESP_OKAY, RESP_SLVERR and the W_/R_ state encodings.
REQ-033 Register storage and byte-strobe write logic SHALL be sub-module axi4_lite_reg_bank (write port with strobes, one async read port); the FSMs SHALL be in the top module.

Verification
REQ-034 Write 0xDEADBEEF to 0x04, WSTRB=1111, BREADY=1 -> BVALID one cycle after handshake, BRESP=00; read 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-035 WVALID 3 cycles before AWVALID -> WREADY low after W captured, BVALID only after AW handshake, data written correctly.
REQ-036 Reg0=0x11223344, write 0x0000A500 WSTRB=0010 -> read reg0=0x1122A544.
REQ-037 Write/read 0x20 (NUM_REGS=8) -> BRESP=10, no register change; RDATA=0, RRESP=10.
REQ-038 RREADY and BREADY held low 5 cycles -> RDATA/BRESP stable, ARREADY/AWREADY/WREADY low; completion on release.
REQ-039 ARESET pulsed while BVALID=1 -> next cycle BVALID=0, all registers read 0x00000000.
